ccsds123b2_selftest_sequencer: RTL

//  Sequences an on-FPGA self-test of ccsds_123b2_core: holds the core in reset, releases it, and joins
//  the core's 64-bit output stream with a golden-reference stream beat by beat.

---
 rtl/ccsds123b2_selftest_pkg.sv | 14 +
 rtl/ccsds123b2_stream_comparator.sv | 63 ++++++
 rtl/ccsds123b2_selftest_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ccsds123b2_selftest_pkg.sv
// Shared types and constants for the CCSDS-123.0-B-2 core self-test sequencer.
package ccsds123b2_selftest_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RST_CORE = 2'd1,
        RUN      = 2'd2,
        DONE     = 2'd3
    } seq_state_t;

    // Truncate to the counter width in use; doubles as the "no mismatch yet" marker.
    localparam logic [63:0] CNT_ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/ccsds123b2_stream_comparator.sv
// Joins the core output stream with the golden stream and keeps beat, mismatch and first-index stats.
module ccsds123b2_stream_comparator
    import ccsds123b2_selftest_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] dut_data,
    input  logic                  dut_valid,
    input  logic [DATA_WIDTH-1:0] gold_data,
    input  logic                  gold_valid,
    output logic                  dut_ready,
    output logic                  gold_ready,
    output logic                  beat,
    output logic                  beat_mismatch,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic [CNT_WIDTH-1:0]  first_mismatch
);

    localparam logic [CNT_WIDTH-1:0] NO_INDEX = CNT_WIDTH'(CNT_ALL_ONES);

    logic [CNT_WIDTH-1:0] word_count_reg;
    logic [CNT_WIDTH-1:0] mismatch_count_reg;
    logic [CNT_WIDTH-1:0] first_mismatch_reg;

    // Neither side is ever consumed alone, so the two streams stay word-aligned.
    assign beat          = enable & dut_valid & gold_valid;
    assign dut_ready     = beat;
    assign gold_ready    = beat;
    assign beat_mismatch = beat & (dut_data != gold_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count_reg     <= '0;
            mismatch_count_reg <= '0;
            first_mismatch_reg <= NO_INDEX;
        end else if (clear) begin
            word_count_reg     <= '0;
            mismatch_count_reg <= '0;
            first_mismatch_reg <= NO_INDEX;
        end else if (beat) begin
            word_count_reg <= word_count_reg + 1'b1;
            if (beat_mismatch) begin
                if (mismatch_count_reg != NO_INDEX) begin
                    mismatch_count_reg <= mismatch_count_reg + 1'b1;
                end
                if (first_mismatch_reg == NO_INDEX) begin
                    first_mismatch_reg <= word_count_reg;
                end
            end
        end
    end

    assign word_count     = word_count_reg;
    assign mismatch_count = mismatch_count_reg;
    assign first_mismatch = first_mismatch_reg;

endmodule

// File: rtl/ccsds123b2_selftest_sequencer.sv
// Self-test sequencer: resets the core, compares its output against the golden stream, reports status.
module ccsds123b2_selftest_sequencer
    import ccsds123b2_selftest_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int CNT_WIDTH      = 32,
    parameter int RESET_CYCLES   = 16,
    parameter int EXPECTED_WORDS = 4881,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  core_rst,
    input  logic [DATA_WIDTH-1:0] dut_data,
    input  logic                  dut_valid,
    input  logic                  dut_last,
    output logic                  dut_ready,
    input  logic [DATA_WIDTH-1:0] gold_data,
    input  logic                  gold_valid,
    output logic                  gold_ready,
    output logic                  busy,
    output logic                  finished,
    output logic                  failed,
    output logic                  len_err,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic [CNT_WIDTH-1:0]  first_mismatch
);

    localparam logic [CNT_WIDTH-1:0] RST_LAST  = CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WORD_LAST = CNT_WIDTH'(EXPECTED_WORDS - 1);
    localparam logic [CNT_WIDTH-1:0] WD_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    seq_state_t state_reg, state_next;

    logic [CNT_WIDTH-1:0] rst_cnt_reg;
    logic [CNT_WIDTH-1:0] wd_cnt_reg;
    logic core_rst_reg, busy_reg, finished_reg, failed_reg, len_err_reg, timeout_reg;

    logic in_run, enter_rst, beat, beat_mismatch, is_final;
    logic len_evt, wd_expire, fail_evt, end_evt;

    assign in_run    = (state_reg == RUN);
    assign enter_rst = start & ((state_reg == IDLE) | (state_reg == DONE));

    ccsds123b2_stream_comparator #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_comparator (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (enter_rst),
        .enable         (in_run),
        .dut_data       (dut_data),
        .dut_valid      (dut_valid),
        .gold_data      (gold_data),
        .gold_valid     (gold_valid),
        .dut_ready      (dut_ready),
        .gold_ready     (gold_ready),
        .beat           (beat),
        .beat_mismatch  (beat_mismatch),
        .word_count     (word_count),
        .mismatch_count (mismatch_count),
        .first_mismatch (first_mismatch)
    );

    // Length error: tlast on a non-final index, or the final index arriving without tlast.
    assign is_final  = (word_count == WORD_LAST);
    assign len_evt   = beat & (dut_last ^ is_final);
    assign wd_expire = in_run & ~beat & (wd_cnt_reg == WD_LAST);
    assign fail_evt  = beat_mismatch | len_evt | wd_expire;
    assign end_evt   = (beat & (dut_last | is_final)) | wd_expire;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (start) state_next = RST_CORE;
            RST_CORE: if (rst_cnt_reg == RST_LAST) state_next = RUN;
            RUN:      if (end_evt) state_next = DONE;
            DONE:     if (start) state_next = RST_CORE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rst_cnt_reg  <= '0;
            wd_cnt_reg   <= '0;
            core_rst_reg <= 1'b1;
            busy_reg     <= 1'b0;
            finished_reg <= 1'b0;
            failed_reg   <= 1'b0;
            len_err_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            // Core is held in reset until the run starts, and left idle (not reset) once done.
            core_rst_reg <= (state_next == IDLE) | (state_next == RST_CORE);
            busy_reg     <= (state_next == RST_CORE) | (state_next == RUN);

            if (enter_rst) begin
                rst_cnt_reg <= '0;
            end else if (state_reg == RST_CORE) begin
                rst_cnt_reg <= rst_cnt_reg + 1'b1;
            end

            if (!in_run || beat) begin
                wd_cnt_reg <= '0;
            end else begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end

            if (enter_rst) begin
                finished_reg <= 1'b0;
                failed_reg   <= 1'b0;
                len_err_reg  <= 1'b0;
                timeout_reg  <= 1'b0;
            end else if (in_run) begin
                if (fail_evt)  failed_reg   <= 1'b1;
                if (len_evt)   len_err_reg  <= 1'b1;
                if (wd_expire) timeout_reg  <= 1'b1;
                if (end_evt)   finished_reg <= 1'b1;
            end
        end
    end

    assign core_rst = core_rst_reg;
    assign busy     = busy_reg;
    assign finished = finished_reg;
    assign failed   = failed_reg;
    assign len_err  = len_err_reg;
    assign timeout  = timeout_reg;

endmodule
